// File: rtl/control_sequencer.sv
`timescale 1ns/1ps
// control_sequencer
// Multi-cycle CPU control FSM. It decodes the 4-bit opcode at the top of the
// instruction register and drives the datapath strobes. Every memory access uses
// a request/ready handshake guarded by a wait-cycle timeout. Vectored interrupt
// entry is taken only at instruction boundaries. A sticky fault flag records
// illegal opcodes and memory timeouts.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-low reset
//   instruction         current instruction register contents
//   Z                   ALU zero flag (conditional jump sense)
//   mem_ready           memory finishes the pending read/write this cycle
//   irq_req, irq_mask   level interrupt request and its block
//   reg_write .. increase_sp   datapath strobes
//   mem_read, mem_write        memory requests, held until mem_ready
//   pc_from_vector, push_pc    interrupt entry controls
//   irq_ack             one-cycle pulse on the vector jump
//   fault               sticky: illegal opcode or memory timeout
//   state               one-hot current state
module control_sequencer #(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          IRQ_ENABLE = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               Z,
  input  logic               mem_ready,
  input  logic               irq_req,
  input  logic               irq_mask,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               fetch_instruction,
  output logic               alu_override_imm8,
  output logic               alu_override_imm4,
  output logic               alu_set_flags,
  output logic               set_pc,
  output logic               pc_from_register,
  output logic               set_sp,
  output logic               increase_sp,
  output logic               mem_read,
  output logic               mem_write,
  output logic               pc_from_vector,
  output logic               push_pc,
  output logic               irq_ack,
  output logic               fault,
  output logic [17:0]        state
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [17:0] {
    S_BOUNDARY  = 18'h00001,
    S_FETCH_REQ = 18'h00002,
    S_DECODE    = 18'h00004,
    S_LOAD_REQ  = 18'h00008,
    S_STORE_REQ = 18'h00010,
    S_PUSH_REQ  = 18'h00020,
    S_PUSH_INC  = 18'h00040,
    S_POP_DEC   = 18'h00080,
    S_POP_REQ   = 18'h00100,
    S_JMP       = 18'h00200,
    S_ALU       = 18'h00400,
    S_IRQ_PUSH  = 18'h00800,
    S_IRQ_INC   = 18'h01000,
    S_IRQ_VEC   = 18'h02000,
    S_HALT      = 18'h04000,
    S_RSVD0     = 18'h08000,
    S_RSVD1     = 18'h10000,
    S_RSVD2     = 18'h20000
  } state_t;

  state_t             state_q, state_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               req_wait;
  logic [3:0]         opcode;
  logic               unused_instr_bits;

  assign opcode            = instruction[INSTR_W-1 -: 4];
  assign unused_instr_bits = ^instruction;
  assign cnt_inc           = cnt_q + CNT_W'(1);
  assign state             = state_q;
  assign fault             = fault_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOUNDARY;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    fault_d           = fault_q;
    cnt_d             = cnt_q;
    req_wait          = 1'b0;
    reg_write         = 1'b0;
    mem_to_reg        = 1'b0;
    fetch_instruction = 1'b0;
    alu_override_imm8 = 1'b0;
    alu_override_imm4 = 1'b0;
    alu_set_flags     = 1'b0;
    set_pc            = 1'b0;
    pc_from_register  = 1'b0;
    set_sp            = 1'b0;
    increase_sp       = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    pc_from_vector    = 1'b0;
    push_pc           = 1'b0;
    irq_ack           = 1'b0;

    case (state_q)
      S_BOUNDARY: begin
        if (IRQ_ENABLE && irq_req && !irq_mask) state_d = S_IRQ_PUSH;
        else                                    state_d = S_FETCH_REQ;
      end
      S_FETCH_REQ: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          fetch_instruction = 1'b1;
          state_d           = S_DECODE;
        end else begin
          req_wait = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          4'b0000: state_d = S_LOAD_REQ;
          4'b0001: state_d = S_STORE_REQ;
          4'b0010: state_d = S_ALU;
          4'b0100: state_d = S_JMP;
          4'b0101: state_d = S_PUSH_REQ;
          4'b0110: state_d = S_POP_DEC;
          4'b0111: state_d = S_HALT;
          4'b1000: state_d = S_ALU;
          4'b1001: state_d = S_ALU;
          default: begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        endcase
      end
      S_LOAD_REQ, S_POP_REQ: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          set_pc     = 1'b1;
          state_d    = S_BOUNDARY;
        end else begin
          req_wait = 1'b1;
        end
      end
      S_STORE_REQ, S_PUSH_REQ: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          set_pc  = 1'b1;
          state_d = (state_q == S_PUSH_REQ) ? S_PUSH_INC : S_BOUNDARY;
        end else begin
          req_wait = 1'b1;
        end
      end
      S_PUSH_INC: begin
        set_sp      = 1'b1;
        increase_sp = 1'b1;
        state_d     = S_BOUNDARY;
      end
      S_POP_DEC: begin
        set_sp  = 1'b1;
        state_d = S_POP_REQ;
      end
      S_JMP: begin
        set_pc           = 1'b1;
        // instruction[7] inverts the sense of the zero-flag condition
        pc_from_register = Z ^ instruction[7];
        state_d          = S_BOUNDARY;
      end
      S_ALU: begin
        reg_write         = 1'b1;
        alu_set_flags     = 1'b1;
        set_pc            = 1'b1;
        alu_override_imm8 = (opcode == 4'b0010);
        alu_override_imm4 = (opcode == 4'b1001);
        state_d           = S_BOUNDARY;
      end
      S_IRQ_PUSH: begin
        mem_write = 1'b1;
        push_pc   = 1'b1;
        if (mem_ready) state_d = S_IRQ_INC;
        else           req_wait = 1'b1;
      end
      S_IRQ_INC: begin
        set_sp      = 1'b1;
        increase_sp = 1'b1;
        state_d     = S_IRQ_VEC;
      end
      S_IRQ_VEC: begin
        set_pc         = 1'b1;
        pc_from_vector = 1'b1;
        irq_ack        = IRQ_ENABLE;
        // The handler's first instruction is fetched without another IRQ check
        state_d        = S_FETCH_REQ;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        // Reserved codes are unreachable; treat any arrival as a fault
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    endcase

    // Wait-cycle watchdog: the TIMEOUT-th consecutive non-ready cycle aborts
    if (TIMEOUT != 0 && req_wait && cnt_inc == CNT_W'(TIMEOUT)) begin
      state_d = S_HALT;
      fault_d = 1'b1;
    end

    // Every REQ state is entered from a different state, so clearing on any
    // transition restarts the count for each new access.
    if (state_d != state_q) cnt_d = '0;
    else if (req_wait)      cnt_d = cnt_inc;
  end

endmodule

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
// Testbench for control_sequencer: builds an expected per-cycle trace for each
// instruction from the instruction-level rules, drives mem_ready from that
// trace and compares every output and the one-hot state each cycle.
module tb_control_sequencer;

  localparam int TO = 4;

  // bench-side bit positions of the packed strobe word
  localparam logic [15:0] RW  = 16'h0001, MTR = 16'h0002, FI  = 16'h0004, I8  = 16'h0008;
  localparam logic [15:0] I4  = 16'h0010, ASF = 16'h0020, SPC = 16'h0040, PFR = 16'h0080;
  localparam logic [15:0] SSP = 16'h0100, ISP = 16'h0200, MR  = 16'h0400, MW  = 16'h0800;
  localparam logic [15:0] PFV = 16'h1000, PPC = 16'h2000, ACK = 16'h4000, FLT = 16'h8000;

  // positions in the documented state list
  localparam int S_B = 0, S_F = 1, S_D = 2, S_LD = 3, S_ST = 4, S_PSH = 5, S_PINC = 6;
  localparam int S_PDEC = 7, S_POP = 8, S_JMP = 9, S_ALU = 10, S_IP = 11, S_II = 12;
  localparam int S_IV = 13, S_HALT = 14;

  logic        clock, reset;
  logic [15:0] instruction;
  logic        Z, mem_ready, irq_req, irq_mask;
  logic        reg_write, mem_to_reg, fetch_instruction, alu_override_imm8, alu_override_imm4;
  logic        alu_set_flags, set_pc, pc_from_register, set_sp, increase_sp;
  logic        mem_read, mem_write, pc_from_vector, push_pc, irq_ack, fault;
  logic [17:0] state;

  control_sequencer #(.INSTR_W(16), .TIMEOUT(TO), .IRQ_ENABLE(1'b1)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .Z(Z),
    .mem_ready(mem_ready), .irq_req(irq_req), .irq_mask(irq_mask),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .fetch_instruction(fetch_instruction),
    .alu_override_imm8(alu_override_imm8), .alu_override_imm4(alu_override_imm4),
    .alu_set_flags(alu_set_flags), .set_pc(set_pc), .pc_from_register(pc_from_register),
    .set_sp(set_sp), .increase_sp(increase_sp), .mem_read(mem_read), .mem_write(mem_write),
    .pc_from_vector(pc_from_vector), .push_pc(push_pc), .irq_ack(irq_ack), .fault(fault),
    .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rdy;
    logic [33:0] exp;
  } rec_t;

  rec_t tq[$];
  int   forced_q[$];
  int   halt_len = 3;
  bit   flt_m, halted_m;
  int   n_vec, n_bad;
  int   n_rw, n_mr, n_ack;
  int   txn_no;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] obs();
    return {state, fault, irq_ack, push_pc, pc_from_vector, mem_write, mem_read,
            increase_sp, set_sp, pc_from_register, set_pc, alu_set_flags,
            alu_override_imm4, alu_override_imm8, fetch_instruction, mem_to_reg, reg_write};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- reference model: expected trace ----------------
  task automatic add(input int st, input logic [15:0] sb, input logic rdy);
    rec_t        r;
    logic [17:0] oh;
    oh     = '0;
    oh[st] = 1'b1;
    r.rdy  = rdy;
    r.exp  = {oh, sb | (flt_m ? FLT : 16'h0)};
    tq.push_back(r);
  endtask

  task automatic pick_delay(output int d);
    if (forced_q.size() > 0) d = forced_q.pop_front();
    else if ($urandom_range(0, 11) == 0) d = 6;
    else d = $urandom_range(0, 3);
  endtask

  task automatic go_halt(input bit f);
    if (f) flt_m = 1'b1;
    for (int k = 0; k < halt_len; k++) add(S_HALT, 16'h0, rnd());
    halted_m = 1'b1;
  endtask

  // memory access: 'hold' during every request cycle, 'done' added on the ready cycle
  task automatic req(input int st, input logic [15:0] hold, input logic [15:0] done);
    int d;
    pick_delay(d);
    if (d >= TO) begin
      for (int k = 0; k < TO; k++) add(st, hold, 1'b0);
      go_halt(1'b1);
    end else begin
      for (int k = 0; k < d; k++) add(st, hold, 1'b0);
      add(st, hold | done, 1'b1);
    end
  endtask

  task automatic build(input logic [15:0] ins, input bit z, input bit irq, input bit mask);
    add(S_B, 16'h0, rnd());
    if (irq && !mask) begin
      req(S_IP, MW | PPC, 16'h0);
      if (halted_m) return;
      add(S_II, SSP | ISP, rnd());
      add(S_IV, SPC | PFV | ACK, rnd());
    end
    req(S_F, MR, FI);
    if (halted_m) return;
    add(S_D, 16'h0, rnd());
    case (ins[15:12])
      4'h0: req(S_LD, MR, RW | MTR | SPC);
      4'h1: req(S_ST, MW, SPC);
      4'h2: add(S_ALU, RW | ASF | SPC | I8, rnd());
      4'h4: add(S_JMP, SPC | ((z ^ ins[7]) ? PFR : 16'h0), rnd());
      4'h5: begin
        req(S_PSH, MW, SPC);
        if (!halted_m) add(S_PINC, SSP | ISP, rnd());
      end
      4'h6: begin
        add(S_PDEC, SSP, rnd());
        req(S_POP, MR, RW | MTR | SPC);
      end
      4'h7: go_halt(1'b0);
      4'h8: add(S_ALU, RW | ASF | SPC, rnd());
      4'h9: add(S_ALU, RW | ASF | SPC | I4, rnd());
      default: go_halt(1'b1);
    endcase
  endtask

  // ---------------- drivers ----------------
  // entered and left at posedge+1
  task automatic apply(input int n, input logic [15:0] ins, input bit z, input bit irq, input bit mask);
    int          lim;
    logic [33:0] ov;
    lim = (n < 0 || n > tq.size()) ? tq.size() : n;
    for (int i = 0; i < lim; i++) begin
      instruction = ins;
      Z           = z;
      irq_req     = irq;
      irq_mask    = mask;
      mem_ready   = tq[i].rdy;
      #3;
      ov = obs();
      if (ov[0])  n_rw++;
      if (ov[10]) n_mr++;
      if (ov[14]) n_ack++;
      check_val($sformatf("t%0d.c%0d", txn_no, i), {30'b0, ov}, {30'b0, tq[i].exp});
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_val("reset_async", {30'b0, obs()}, {30'b0, 18'h00001, 16'h0000});
    @(posedge clock);
    #1;
    check_val("reset_hold", {30'b0, obs()}, {30'b0, 18'h00001, 16'h0000});
    @(posedge clock);
    #1;
    reset = 1'b1;
    flt_m = 1'b0;
  endtask

  task automatic txn(input logic [15:0] ins, input bit z, input bit irq, input bit mask);
    tq.delete();
    halted_m = 1'b0;
    build(ins, z, irq, mask);
    apply(-1, ins, z, irq, mask);
    $display("txn %0d ins=%h z=%b irq=%b mask=%b cycles=%0d halted=%b",
             txn_no, ins, z, irq, mask, tq.size(), halted_m);
    txn_no++;
    if (halted_m) do_reset();
  endtask

  task automatic clr_counts();
    n_rw  = 0;
    n_mr  = 0;
    n_ack = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_bad = 0; txn_no = 0; flt_m = 1'b0;
    instruction = 16'h0; Z = 1'b0; mem_ready = 1'b0; irq_req = 1'b0; irq_mask = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check_val("reset_state", {30'b0, obs()}, {30'b0, 18'h00001, 16'h0000});
    @(posedge clock);
    #1;
    check_val("reset_hold0", {30'b0, obs()}, {30'b0, 18'h00001, 16'h0000});
    @(posedge clock);
    #1;
    reset = 1'b1;

    // ALU with immediate ready: 4-cycle instruction
    forced_q = {0};
    txn(16'h8123, 1'b0, 1'b0, 1'b0);

    // LOAD with the data read delayed 3 cycles
    clr_counts();
    forced_q = {0, 3};
    txn(16'h0000, 1'b0, 1'b0, 1'b0);
    check_val("ld_mem_read_cycles", 64'(n_mr), 64'd5);
    check_val("ld_reg_write_pulses", 64'(n_rw), 64'd1);

    // interrupt taken, then masked
    clr_counts();
    forced_q = {0, 0};
    txn(16'h8123, 1'b0, 1'b1, 1'b0);
    check_val("irq_ack_pulses", 64'(n_ack), 64'd1);
    clr_counts();
    forced_q = {0};
    txn(16'h8123, 1'b0, 1'b1, 1'b1);
    check_val("irq_masked_ack", 64'(n_ack), 64'd0);

    // conditional jump and immediate forms
    forced_q = {0};
    txn(16'h4080, 1'b0, 1'b0, 1'b0);
    forced_q = {0};
    txn(16'h4080, 1'b1, 1'b0, 1'b0);
    forced_q = {0};
    txn(16'h2055, 1'b0, 1'b0, 1'b0);
    forced_q = {0};
    txn(16'h9007, 1'b0, 1'b0, 1'b0);

    // illegal opcode: absorbing HALT with fault
    halt_len = 20;
    forced_q = {0};
    txn(16'hF000, 1'b0, 1'b0, 1'b0);
    halt_len = 3;

    // HALT opcode leaves fault clear
    forced_q = {0};
    txn(16'h7000, 1'b0, 1'b0, 1'b0);

    // fetch never ready: timeout after TO wait cycles
    forced_q = {9};
    txn(16'h8123, 1'b0, 1'b0, 1'b0);

    // reset pulled during a LOAD data wait
    tq.delete();
    halted_m = 1'b0;
    forced_q = {0, 3};
    build(16'h0000, 1'b0, 1'b0, 1'b0);
    apply(5, 16'h0000, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #2;
    check_val("ld_wait_read", {63'b0, mem_read}, 64'd1);
    reset = 1'b0;
    #1;
    check_val("rst_mid_load", {30'b0, obs()}, {30'b0, 18'h00001, 16'h0000});
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    flt_m = 1'b0;
    $display("txn %0d reset during LOAD wait", txn_no);
    txn_no++;
    forced_q = {0};
    txn(16'h8001, 1'b0, 1'b0, 1'b0);

    // randomized instruction stream
    for (int t = 0; t < 200; t++) begin
      txn(16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
